// File: rtl/pc_fetch_unit_if.sv
// Fetch-stage bus between the PC unit and its surrounding datapath/imem.
// master = pc_fetch_unit, slave = the environment that feeds it.
interface pc_fetch_if;
    logic [31:0] instr;
    logic [1:0]  pc_src;
    logic        branch_taken;
    logic [31:0] rs_data;
    logic        stall;
    logic        irq;
    logic        exc;
    logic        eret;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic        kernel;
    logic        flush;
    logic        irq_ack;

    modport master (
        input  instr, pc_src, branch_taken, rs_data, stall, irq, exc, eret,
        output pc, pc_plus4, epc, kernel, flush, irq_ack
    );

    modport slave (
        output instr, pc_src, branch_taken, rs_data, stall, irq, exc, eret,
        input  pc, pc_plus4, epc, kernel, flush, irq_ack
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter / fetch sequencer: next-PC selection, interrupt and
// exception vectoring, EPC save and kernel-mode tracking.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] IRQ_PC   = 32'h0000_0004,
    parameter logic [31:0] EXC_PC   = 32'h0000_0008
) (
    input  logic          clk,
    input  logic          reset,
    pc_fetch_if.master    bus
);

    typedef enum logic {
        MODE_USER   = 1'b0,
        MODE_KERNEL = 1'b1
    } mode_t;

    mode_t       mode, mode_next;
    logic [31:0] pc_q, pc_next;
    logic [31:0] epc_q, epc_next;
    logic        ack_q, ack_next;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic        irq_take;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_plus4 + {{14{bus.instr[15]}}, bus.instr[15:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], bus.instr[25:0], 2'b00};
    assign jr_target     = {bus.rs_data[31:2], 2'b00};

    // Interrupts are masked in kernel mode and lose to a same-cycle exception.
    assign irq_take = bus.irq & (mode == MODE_USER) & ~bus.exc;

    always_comb begin
        pc_next   = pc_q;
        epc_next  = epc_q;
        mode_next = mode;
        ack_next  = 1'b0;
        if (bus.exc) begin
            pc_next   = EXC_PC;
            mode_next = MODE_KERNEL;
            if (mode == MODE_USER)
                epc_next = pc_q;
        end else if (irq_take) begin
            pc_next   = IRQ_PC;
            epc_next  = pc_q;
            mode_next = MODE_KERNEL;
            ack_next  = 1'b1;
        end else if (!bus.stall) begin
            if (bus.eret) begin
                pc_next   = epc_q;
                mode_next = MODE_USER;
            end else begin
                unique case (bus.pc_src)
                    2'b00:   pc_next = pc_plus4;
                    2'b01:   pc_next = bus.branch_taken ? branch_target : pc_plus4;
                    2'b10:   pc_next = jump_target;
                    default: pc_next = jr_target;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            epc_q <= '0;
            mode  <= MODE_USER;
            ack_q <= 1'b0;
        end else begin
            pc_q  <= pc_next;
            epc_q <= epc_next;
            mode  <= mode_next;
            ack_q <= ack_next;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.epc      = epc_q;
    assign bus.kernel   = (mode == MODE_KERNEL);
    assign bus.irq_ack  = ack_q;
    assign bus.flush    = ~reset & (bus.exc | irq_take);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed vectors push hand-computed
// expectations, a monitor checks flush before the edge and state after it.
module tb_pc_fetch_unit;

    logic clk = 1'b1;
    logic reset;
    always #5 clk = ~clk;

    pc_fetch_if bus ();

    pc_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .IRQ_PC   (32'h0000_0004),
        .EXC_PC   (32'h0000_0008)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct {
        string       name;
        logic        flush;
        logic [31:0] pc;
        logic [31:0] epc;
        logic        kernel;
        logic        ack;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // One cycle of stimulus: drive inputs mid-low-phase and queue expectations.
    task automatic vec(input string name, input logic rst, input logic [31:0] instr,
                       input logic [1:0] src, input logic taken, input logic [31:0] rs,
                       input logic stall, input logic irq, input logic exc, input logic eret,
                       input logic e_flush, input logic [31:0] e_pc, input logic [31:0] e_epc,
                       input logic e_kernel, input logic e_ack);
        exp_t e;
        @(negedge clk);
        reset            = rst;
        bus.instr        = instr;
        bus.pc_src       = src;
        bus.branch_taken = taken;
        bus.rs_data      = rs;
        bus.stall        = stall;
        bus.irq          = irq;
        bus.exc          = exc;
        bus.eret         = eret;
        e.name = name; e.flush = e_flush; e.pc = e_pc; e.epc = e_epc;
        e.kernel = e_kernel; e.ack = e_ack;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #4;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk({e.name, ".flush"}, {31'b0, bus.flush}, {31'b0, e.flush});
                @(posedge clk);
                #1;
                chk({e.name, ".pc"},       bus.pc,       e.pc);
                chk({e.name, ".pc_plus4"}, bus.pc_plus4, e.pc + 32'd4);
                chk({e.name, ".epc"},      bus.epc,      e.epc);
                chk({e.name, ".kernel"},   {31'b0, bus.kernel},  {31'b0, e.kernel});
                chk({e.name, ".irq_ack"},  {31'b0, bus.irq_ack}, {31'b0, e.ack});
            end
        end
    end

    initial begin : stimulus
        int waited;
        reset = 1'b1;
        bus.instr = '0; bus.pc_src = 2'b00; bus.branch_taken = 1'b0; bus.rs_data = '0;
        bus.stall = 1'b0; bus.irq = 1'b0; bus.exc = 1'b0; bus.eret = 1'b0;

        //   name        rst instr          src  tk rs             st irq exc eret  fl  pc             epc            k  ack
        vec("reset0",    1, 32'h0,          2'b00,0,32'h0,         0, 0,  0,  0,    0, 32'h0,         32'h0,         0, 0);
        vec("seq1",      0, 32'h0,          2'b00,0,32'h0,         0, 0,  0,  0,    0, 32'h4,         32'h0,         0, 0);
        vec("seq2",      0, 32'h0,          2'b00,0,32'h0,         0, 0,  0,  0,    0, 32'h8,         32'h0,         0, 0);
        vec("seq3",      0, 32'h0,          2'b00,0,32'h0,         0, 0,  0,  0,    0, 32'hC,         32'h0,         0, 0);
        vec("br_taken",  0, 32'h1085_0003,  2'b01,1,32'h0,         0, 0,  0,  0,    0, 32'h1C,        32'h0,         0, 0);
        vec("reset1",    1, 32'h0,          2'b00,0,32'h0,         0, 0,  0,  0,    0, 32'h0,         32'h0,         0, 0);
        vec("jump",      0, 32'h0800_000E,  2'b10,0,32'h0,         0, 0,  0,  0,    0, 32'h38,        32'h0,         0, 0);
        vec("reset2",    1, 32'h0,          2'b00,0,32'h0,         0, 0,  0,  0,    0, 32'h0,         32'h0,         0, 0);
        vec("seq4",      0, 32'h0,          2'b00,0,32'h0,         0, 0,  0,  0,    0, 32'h4,         32'h0,         0, 0);
        vec("seq5",      0, 32'h0,          2'b00,0,32'h0,         0, 0,  0,  0,    0, 32'h8,         32'h0,         0, 0);
        vec("seq6",      0, 32'h0,          2'b00,0,32'h0,         0, 0,  0,  0,    0, 32'hC,         32'h0,         0, 0);
        vec("br_not",    0, 32'h1085_0003,  2'b01,0,32'h0,         0, 0,  0,  0,    0, 32'h10,        32'h0,         0, 0);
        vec("br_neg",    0, 32'h1000_FFFF,  2'b01,1,32'h0,         0, 0,  0,  0,    0, 32'h10,        32'h0,         0, 0);
        vec("jr",        0, 32'h0,          2'b11,0,32'h57,        0, 0,  0,  0,    0, 32'h54,        32'h0,         0, 0);
        vec("stall1",    0, 32'h1000_0010,  2'b01,1,32'h0,         1, 0,  0,  1,    0, 32'h54,        32'h0,         0, 0);
        vec("stall2",    0, 32'h0,          2'b11,0,32'h100,       1, 0,  0,  0,    0, 32'h54,        32'h0,         0, 0);
        vec("jr_3c",     0, 32'h0,          2'b11,0,32'h3C,        0, 0,  0,  0,    0, 32'h3C,        32'h0,         0, 0);
        vec("irq_take",  0, 32'h0,          2'b00,0,32'h0,         0, 1,  0,  0,    1, 32'h4,         32'h3C,        1, 1);
        vec("irq_mask",  0, 32'h0,          2'b00,0,32'h0,         0, 1,  0,  0,    0, 32'h8,         32'h3C,        1, 0);
        vec("eret1",     0, 32'h0,          2'b10,0,32'h0,         0, 1,  0,  1,    0, 32'h3C,        32'h3C,        0, 0);
        vec("irq_again", 0, 32'h0,          2'b00,0,32'h0,         0, 1,  0,  0,    1, 32'h4,         32'h3C,        1, 1);
        vec("eret2",     0, 32'h0,          2'b00,0,32'h0,         0, 0,  0,  1,    0, 32'h3C,        32'h3C,        0, 0);
        vec("jr_20",     0, 32'h0,          2'b11,0,32'h20,        0, 0,  0,  0,    0, 32'h20,        32'h3C,        0, 0);
        vec("exc_stall", 0, 32'h0,          2'b00,0,32'h0,         1, 0,  1,  0,    1, 32'h8,         32'h20,        1, 0);
        vec("exc_nest",  0, 32'h0,          2'b00,0,32'h0,         0, 0,  1,  0,    1, 32'h8,         32'h20,        1, 0);
        vec("reset_krn", 1, 32'h0,          2'b00,0,32'h0,         1, 1,  1,  0,    0, 32'h0,         32'h0,         0, 0);
        vec("exc_irq",   0, 32'h0,          2'b00,0,32'h0,         0, 1,  1,  0,    1, 32'h8,         32'h0,         1, 0);
        vec("post_exc",  0, 32'h0,          2'b00,0,32'h0,         0, 1,  0,  0,    0, 32'hC,         32'h0,         1, 0);
        vec("jr_top",    0, 32'h0,          2'b11,0,32'hFFFF_FFFF, 0, 0,  0,  0,    0, 32'hFFFF_FFFC, 32'h0,         1, 0);
        vec("wrap",      0, 32'h0,          2'b00,0,32'h0,         0, 0,  0,  0,    0, 32'h0,         32'h0,         1, 0);
        vec("eret3",     0, 32'h0,          2'b00,0,32'h0,         0, 0,  0,  1,    0, 32'h0,         32'h0,         0, 0);

        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and fetch-sequencing stage of the single-cycle MIPS core. It sits directly upstream of the instruction memory: it drives the word address each cycle and computes the next PC from sequential, branch, jump and jump-register sources. It also vectors to the interrupt and exception handlers through the low vector table (reset 0x0, interrupt 0x4, exception 0x8), saves the return PC in an EPC register and tracks kernel mode until `eret`.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset
- `IRQ_PC`, 32'h0000_0004, interrupt vector
- `EXC_PC`, 32'h0000_0008, exception (illegal-op) vector
- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: synchronous, active-high
- `instr` in 32: instruction currently fetched at `pc` (from instruction memory)
- `pc_src` in 2: 00 sequential, 01 branch, 10 jump (J/JAL), 11 jump-register (JR/JALR)
- `branch_taken` in 1: branch condition result, qualifies `pc_src`=01
- `rs_data` in 32: register value for jump-register
- `stall` in 1: hold PC this cycle
- `irq` in 1: level-sensitive interrupt request
- `exc` in 1: illegal-instruction exception for the instruction at `pc`
- `eret` in 1: return from handler
- `pc` out 32: current PC, drives the instruction memory address
- `pc_plus4` out 32: `pc`+4 (link value for JAL/JALR)
- `epc` out 32: saved return address
- `kernel` out 1: handler mode flag
- `flush` out 1: combinational; squash register/memory writes of the current instruction
- `irq_ack` out 1: registered one-cycle pulse after an interrupt is taken

## Operation
- Targets (32-bit, wrap modulo 2^32): branch = `pc_plus4` + (sign-extended `instr[15:0]` << 2); jump = {`pc_plus4[31:28]`, `instr[25:0]`, 2'b00}; jump-register = {`rs_data[31:2]`, 2'b00} (low bits forced to zero).
- `pc_src`=01 with `branch_taken`=0 acts as sequential.
- Interrupt accepted = `irq` & ~`kernel` & ~`exc`.
- Next-state priority, highest first:
  - `reset`: `pc`=RESET_PC, `epc`=0, `kernel`=0, `irq_ack`=0.
  - `exc`: `pc`=EXC_PC, `kernel`=1; `epc`=`pc` only if `kernel` was 0 (a nested exception keeps the old EPC). `flush`=1.
  - accepted interrupt: `pc`=IRQ_PC, `epc`=`pc` (the interrupted instruction is squashed and re-executed after return), `kernel`=1, `irq_ack`=1 next cycle. `flush`=1.
  - `stall`: `pc`, `epc` and `kernel` hold. `eret` and `pc_src` are ignored.
  - `eret`: `pc`=`epc`, `kernel`=0. `pc_src` is ignored.
  - otherwise `pc` = the target selected by `pc_src`.
- `exc` and an accepted interrupt both override `stall`.
- `irq` is masked while `kernel`=1. A request still asserted after `eret` is taken on the first cycle with `kernel`=0.
- `flush` is 0 in every other case, including reset.

## Timing
- `pc`, `epc`, `kernel`, `irq_ack` are registered. `pc_plus4` and `flush` are combinational from current state and inputs.
- Reset values: `pc`=RESET_PC, `pc_plus4`=RESET_PC+4, `epc`=0, `kernel`=0, `irq_ack`=0, `flush`=0.
- Zero-cycle fetch latency: `pc` changes one cycle after the deciding inputs, and `instr` is valid in that same cycle.
- `irq_ack` is high for exactly one cycle, the cycle in which `pc`=IRQ_PC.
- Reset asserted mid-handler clears `kernel` and `epc` regardless of `stall`/`exc`/`irq`.
- `pc`=0xFFFF_FFFC sequential wraps to 0x0000_0000.

## Test plan
- Reset, then 3 sequential cycles -> `pc` 0x0, 0x4, 0x8, 0xC; `flush`=0, `kernel`=0.
- At `pc`=0x0 with `instr`=0x0800_000E, `pc_src`=10 -> `pc`=0x38. At `pc`=0xC with `instr`=0x1085_0003, `pc_src`=01, taken -> `pc`=0x1C. Same case not taken -> 0x10. Offset 0xFFFF at `pc`=0x10 -> 0x10.
- `pc_src`=11, `rs_data`=0x0000_0057 -> `pc`=0x54. `stall` for 2 cycles -> `pc` holds both cycles.
- `irq`=1 at `pc`=0x3C, `kernel`=0 -> `flush`=1 that cycle. Next cycle `pc`=0x4, `epc`=0x3C, `kernel`=1, `irq_ack`=1. `irq` held -> no re-entry. `eret` -> `pc`=0x3C, `kernel`=0, then re-entry on the next cycle.
- `exc` with `kernel`=0 at `pc`=0x20 and `stall`=1 -> `pc`=0x8, `epc`=0x20. Second `exc` at `pc`=0x8 -> `pc`=0x8, `epc` stays 0x20. `exc` and `irq` together -> exception vector wins and `irq_ack` stays 0.
- `reset` while `kernel`=1 and `epc`=0x20 -> next cycle `pc`=0x0, `epc`=0, `kernel`=0.
